if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage_if_id_reg.sv | 38 +++
 rtl/if_stage.sv | 118 +++++++++++
 tb/tb_if_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM encoding,
// datapath widths and the bubble instruction.
package if_stage_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 5;
    localparam logic [XLEN-1:0] DEFAULT_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold; when neither
// loading nor held, the consumed instruction is replaced by a bubble.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_inst,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= NOP_INST;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end else if (!hold) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem fetch FSM, a one-entry
// hold buffer for responses arriving under decode stall, and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            id_stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_inst,
    output logic [OP_W-1:0] if_id_op
);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            hold_valid_reg;
    logic [XLEN-1:0] hold_pc_reg, hold_inst_reg;
    logic            hold_load, ifid_load, from_hold;
    logic [XLEN-1:0] ifid_pc_in, ifid_inst_in;

    // In S_DROP a redirect keeps waiting for the orphaned response, so the
    // single-outstanding rule holds even across back-to-back redirects.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        hold_load  = 1'b0;
        ifid_load  = 1'b0;
        from_hold  = 1'b0;
        case (state_reg)
            S_REQ: begin
                if (redirect)      state_next = imem_gnt ? S_DROP : S_REQ;
                else if (imem_gnt) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    state_next = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    pc_next = pc_reg + 32'd4;
                    if (id_stall) begin
                        hold_load  = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        ifid_load  = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_next = S_REQ;
                end else if (!id_stall) begin
                    ifid_load  = hold_valid_reg;
                    from_hold  = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
        if (redirect) pc_next = align_word(redirect_pc);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= S_REQ;
            pc_reg         <= align_word(RESET_PC);
            hold_valid_reg <= 1'b0;
            hold_pc_reg    <= '0;
            hold_inst_reg  <= NOP_INST;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (redirect || from_hold) begin
                hold_valid_reg <= 1'b0;
            end else if (hold_load) begin
                hold_valid_reg <= 1'b1;
                hold_pc_reg    <= pc_reg;
                hold_inst_reg  <= imem_rdata;
            end
        end
    end

    assign imem_req     = rstn && (state_reg == S_REQ);
    assign imem_addr    = pc_reg;
    assign ifid_pc_in   = from_hold ? hold_pc_reg   : pc_reg;
    assign ifid_inst_in = from_hold ? hold_inst_reg : imem_rdata;

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk       (clk),
        .rstn      (rstn),
        .load      (ifid_load),
        .hold      (id_stall),
        .flush     (redirect),
        .load_pc   (ifid_pc_in),
        .load_inst (ifid_inst_in),
        .valid     (if_id_valid),
        .pc        (if_id_pc),
        .inst      (if_id_inst)
    );

    assign if_id_op = if_id_inst[6:2];

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: an imem responder, random stall/redirect, and
// a scoreboard holding the architectural instruction stream decode must see.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic [4:0]  if_id_op;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst),
        .if_id_op    (if_id_op)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    fetch_t      exp_q[$];
    logic [31:0] fill_pc;
    int          checks   = 0;
    int          failures = 0;
    int          consumed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Sequential program order from the current start point, wrapping mod 2^32.
    function automatic void top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back({fill_pc, mem_word(fill_pc)});
            fill_pc = fill_pc + 32'd4;
        end
    endfunction

    function automatic void restart_stream(input logic [31:0] start);
        exp_q.delete();
        fill_pc = {start[31:2], 2'b00};
        top_up();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        check({tag, "_pc"},    if_id_pc, 32'd0);
        check({tag, "_inst"},  if_id_inst, NOP);
        check({tag, "_op"},    {27'd0, if_id_op}, 32'd4);
        check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    endtask

    // Monitor: every cycle where decode takes an instruction, compare it
    // against the head of the expected stream.
    initial begin
        bit          p_hold;
        logic        p_valid;
        logic [31:0] p_pc, p_inst;
        fetch_t      e;
        p_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                p_hold = 1'b0;
                continue;
            end
            check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            check("op_field", {27'd0, if_id_op}, {27'd0, if_id_inst[6:2]});
            if (!if_id_valid) check("bubble_inst", if_id_inst, NOP);
            if (p_hold) begin
                check("stall_hold_valid", {31'd0, if_id_valid}, {31'd0, p_valid});
                check("stall_hold_pc", if_id_pc, p_pc);
                check("stall_hold_inst", if_id_inst, p_inst);
            end
            p_hold  = id_stall && !redirect;
            p_valid = if_id_valid;
            p_pc    = if_id_pc;
            p_inst  = if_id_inst;
            if (if_id_valid && !id_stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL consume_unexpected actual_pc=%h required=none", if_id_pc);
                end else begin
                    e = exp_q.pop_front();
                    $display("consume pc=%h inst=%h expected_pc=%h", if_id_pc, if_id_inst, e.pc);
                    check("consume_pc", if_id_pc, e.pc);
                    check("consume_inst", if_id_inst, e.inst);
                    consumed++;
                    top_up();
                end
            end
        end
    end

    // Driver: imem responder plus random stall/redirect and one mid-fetch reset.
    initial begin
        logic        hs, rv, outstanding, reset_pending;
        logic [31:0] a, out_addr;
        int          delay;
        id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        outstanding = 1'b0; reset_pending = 1'b0; out_addr = '0; delay = 0;
        restart_stream(RESET_PC);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rstn = 1'b1;
        #1;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RESET_PC);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            hs = imem_req && imem_gnt;
            a  = imem_addr;
            rv = imem_rvalid;
            @(posedge clk);
            #1;
            if (hs) check("one_outstanding", {31'd0, outstanding}, 32'd0);
            if (rv) outstanding = 1'b0;
            if (hs) begin
                outstanding = 1'b1;
                out_addr    = a;
                delay       = $urandom_range(0, 2);
            end
            if (cyc == 2000) reset_pending = 1'b1;
            if (reset_pending && outstanding) begin
                rstn = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
                redirect = 1'b0; id_stall = 1'b0;
                #1;
                check_reset_outputs("midreset");
                outstanding = 1'b0;
                reset_pending = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                restart_stream(RESET_PC);
                rstn = 1'b1;
                #1;
                check("rerelease_req", {31'd0, imem_req}, 32'd1);
                check("rerelease_addr", imem_addr, RESET_PC);
                continue;
            end
            if (outstanding && delay == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(out_addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
                if (outstanding) delay--;
            end
            imem_gnt = ($urandom_range(0, 3) != 0);
            id_stall = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 29) == 0);
            if (redirect) begin
                redirect_pc = ($urandom_range(0, 2) == 0) ?
                              (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
                restart_stream(redirect_pc);
            end
        end

        checks++;
        if (consumed < 200) begin
            failures++;
            $display("FAIL progress actual=%0d required>=200", consumed);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
